bus_resp: RTL and testbench
===========================

BUS_RESP -- requirements
Module: bus_resp

Interface
REQ-001 Parameter RAM_AW, default 12, internal RAM address width; RAM occupies 0x0000 to 2^RAM_AW-1.
REQ-002 Parameter IO_PAGE, default 8'hD0, high address byte selecting the I/O register page.
REQ-003 Parameter IO_WAIT, default 2, number of stall cycles for an I/O access (0..15).
REQ-004 clk  in  1  system clock; all state changes on rising edge.
REQ-005 RST  in  1  reset, synchronous, active-high.
REQ-006 AD  in  16  CPU address, combinational from CPU, held while RDY=0.
REQ-007 DO  in  8  CPU write data.
REQ-008 WE  in  1  CPU write enable.
REQ-009 DI  out  8  registered read data to CPU.
REQ-010 RDY  out  1  CPU ready; 0 stalls the CPU.
REQ-011 IRQ  out  1  interrupt request to CPU, active-high.
REQ-012 irq_src  in  8  peripheral event pulses, one bit per source.
REQ-013 ext_req, ext_we  out  1 each  external bus request / write qualifier.
REQ-014 ext_addr  out  16;  ext_wdata  out  8;  ext_rdata  in  8;  ext_ack  in  1  external bus port.

Function
REQ-015 Decode each cycle: RAM hit if AD < 2^RAM_AW; IO hit if AD[15:8]==IO_PAGE; any other address is an EXT hit.
REQ-016 FSM states IDLE, IOWAIT, EXT; RAM accesses never leave IDLE.
REQ-017 RAM: RDY=1 in the address cycle; a write stores DO at the clock edge; a read registers mem[AD] into DI, valid the following cycle.
REQ-018 IO when IO_WAIT>0: IDLE drives RDY=0 and goes to IOWAIT with wcnt=IO_WAIT-1; IOWAIT keeps RDY=0 while wcnt!=0, decrementing; at wcnt==0 it drives RDY=1, performs the access, and returns to IDLE.
REQ-019 IO when IO_WAIT==0: behaves like RAM timing, with the access completing in IDLE.
REQ-020 IO registers, selected by AD[1:0]: 0 = scratch (R/W); 1 = status (read; write 1 to clear per bit); 2 = enable (R/W); 3 = free-running 8-bit cycle counter (read-only; writes ignored); AD[7:2] is ignored.
REQ-021 status[i] sets on irq_src[i]=1 each cycle; if a set and a write-1-clear hit the same bit in the same cycle, the set wins.
REQ-022 IRQ is registered and equals |(status & enable), one cycle after the state that produces it.
REQ-023 EXT: IDLE drives RDY=0 and goes to EXT; in EXT, ext_req=1 with ext_addr=AD, ext_we=WE, ext_wdata=DO held stable until ext_ack.
REQ-024 In the ext_ack cycle, RDY=1 (combinational from ext_ack) and DI<=ext_rdata on reads; the FSM returns to IDLE and ext_req falls the next cycle; ext_ack outside EXT is ignored.
REQ-025 RDY is combinational from AD, state, wcnt and ext_ack only; DO, DI and IRQ feed no combinational path into RDY.
REQ-026 DI holds its last value through stalls and writes; an unaccessed cycle leaves DI unchanged.
REQ-027 Back-to-back accesses: a new decode starts in the cycle after the IDLE return, with no bubble.

Reset
REQ-028 While RST=1 at an edge: state=IDLE, wcnt=0, DI=8'h00, IRQ=0, ext_req=0, status=0, enable=0, scratch=0, counter=0.
REQ-029 RDY is forced to 1 and ext_req to 0 combinationally while RST=1; a reset during EXT or IOWAIT abandons the access without a RAM or IO write.
REQ-030 RAM contents are not reset.

Structure
REQ-031 The shared package holds the FSM state enum, IO register offsets (IO_SCRATCH, IO_STATUS, IO_ENABLE, IO_COUNT) and default parameter constants.
REQ-032 One sub-module, io_regs, contains the IO register file, counter and IRQ logic; the FSM, decode and RAM stay in bus_resp.

Verification
REQ-033 Write 0x5A to 0x0010, then read 0x0010 -> RDY stays 1 throughout; DI=0x5A one cycle after the read address.
REQ-034 With IO_WAIT=2, read 0xD002 after writing enable=0x81 -> RDY=0 for exactly 2 cycles; DI=0x81 the cycle after RDY returns to 1.
REQ-035 Pulse irq_src=0x01 with enable=0x01 -> IRQ=1 one cycle later; write 0x01 to 0xD001 -> IRQ=0 one cycle after; a simultaneous pulse and clear leaves status[0]=1.
REQ-036 Read 0xFFFC with ext_ack delayed 3 cycles, ext_rdata=0x34 -> ext_req high for 3 cycles plus the ack cycle with ext_addr=0xFFFC; DI=0x34; RDY low until the ack cycle.
REQ-037 Assert RST during EXT -> ext_req=0 and RDY=1 immediately; after release, state=IDLE and DI=0x00.
REQ-038 Write 0x77 to 0xD003 -> the counter is unaffected; two reads 4 cycles apart differ by the elapsed cycle count, mod 256.

Source files
------------

// File: rtl/bus_resp_pkg.sv
// Shared types and constants for the bus responder: FSM states, I/O register
// offsets and default parameter values.
package bus_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IOWAIT = 2'd1,
    ST_EXT    = 2'd2
  } state_t;

  localparam logic [1:0] IO_SCRATCH = 2'd0;
  localparam logic [1:0] IO_STATUS  = 2'd1;
  localparam logic [1:0] IO_ENABLE  = 2'd2;
  localparam logic [1:0] IO_COUNT   = 2'd3;

  localparam int         DEF_RAM_AW  = 12;
  localparam logic [7:0] DEF_IO_PAGE = 8'hD0;
  localparam int         DEF_IO_WAIT = 2;

endpackage

// File: rtl/io_regs.sv
// I/O register page: scratch, sticky status with write-1-clear, enable mask,
// free-running cycle counter and the registered interrupt request.
module io_regs
  import bus_resp_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_acc,
  input  logic       i_we,
  input  logic [1:0] i_sel,
  input  logic [7:0] i_wdata,
  input  logic [7:0] i_irq_src,
  output logic [7:0] o_rdata,
  output logic       o_irq
);

  logic [7:0] r_scratch;
  logic [7:0] r_status;
  logic [7:0] r_enable;
  logic [7:0] r_count;
  logic       r_irq;
  logic       w_wr;
  logic [7:0] w_clr;

  assign w_wr  = i_acc & i_we;
  assign w_clr = (w_wr && (i_sel == IO_STATUS)) ? i_wdata : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scratch <= 8'h00;
      r_status  <= 8'h00;
      r_enable  <= 8'h00;
      r_count   <= 8'h00;
      r_irq     <= 1'b0;
    end else begin
      r_count <= r_count + 8'd1;
      if (w_wr && (i_sel == IO_SCRATCH)) r_scratch <= i_wdata;
      if (w_wr && (i_sel == IO_ENABLE))  r_enable  <= i_wdata;
      // New events are OR-ed in after the clear so a same-cycle set survives.
      r_status <= (r_status & ~w_clr) | i_irq_src;
      r_irq    <= |(r_status & r_enable);
    end
  end

  always_comb begin
    o_rdata = 8'h00;
    case (i_sel)
      IO_SCRATCH: o_rdata = r_scratch;
      IO_STATUS:  o_rdata = r_status;
      IO_ENABLE:  o_rdata = r_enable;
      IO_COUNT:   o_rdata = r_count;
      default:    o_rdata = 8'h00;
    endcase
  end

  assign o_irq = r_irq;

endmodule

// File: rtl/bus_resp.sv
// CPU bus responder: decodes each address cycle into internal RAM, the I/O
// register page (with programmable wait states) or the external bus.
module bus_resp
  import bus_resp_pkg::*;
#(
  parameter int         RAM_AW  = DEF_RAM_AW,
  parameter logic [7:0] IO_PAGE = DEF_IO_PAGE,
  parameter int         IO_WAIT = DEF_IO_WAIT
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [15:0] AD,
  input  logic [7:0]  DO,
  input  logic        WE,
  output logic [7:0]  DI,
  output logic        RDY,
  output logic        IRQ,
  input  logic [7:0]  irq_src,
  output logic        ext_req,
  output logic        ext_we,
  output logic [15:0] ext_addr,
  output logic [7:0]  ext_wdata,
  input  logic [7:0]  ext_rdata,
  input  logic        ext_ack,
  output state_t      dbg_state
);

  localparam logic [3:0] WAIT_INIT = 4'((IO_WAIT > 0) ? (IO_WAIT - 1) : 0);
  localparam bit         IO_ZERO   = (IO_WAIT == 0);

  logic [7:0]  r_mem [0:(2**RAM_AW)-1];
  state_t      r_state;
  logic [3:0]  r_wcnt;
  logic [7:0]  r_di;
  logic        r_ext_req;
  logic        r_ext_we;
  logic [15:0] r_ext_addr;
  logic [7:0]  r_ext_wdata;

  logic        w_ram_hit;
  logic        w_io_hit;
  logic        w_rdy_fsm;
  logic        w_ram_do;
  logic        w_io_do;
  logic        w_io_acc;
  logic        w_ram_we;
  logic [7:0]  w_io_rdata;

  assign w_ram_hit = ((32'(AD) >> RAM_AW) == 32'd0);
  assign w_io_hit  = !w_ram_hit && (AD[15:8] == IO_PAGE);

  // Handshake: the CPU presents AD/DO/WE and holds them while RDY=0; the
  // access completes in the cycle where RDY=1, read data appears on DI next.
  always_comb begin
    w_rdy_fsm = 1'b1;
    w_ram_do  = 1'b0;
    w_io_do   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ram_hit) begin
          w_ram_do = 1'b1;
        end else if (w_io_hit) begin
          if (IO_ZERO) w_io_do = 1'b1;
          else         w_rdy_fsm = 1'b0;
        end else begin
          w_rdy_fsm = 1'b0;
        end
      end
      ST_IOWAIT: begin
        if (r_wcnt == 4'd0) w_io_do = 1'b1;
        else                w_rdy_fsm = 1'b0;
      end
      ST_EXT:  w_rdy_fsm = ext_ack;
      default: w_rdy_fsm = 1'b1;
    endcase
  end

  assign RDY      = RST | w_rdy_fsm;
  assign w_io_acc = w_io_do & ~RST;
  assign w_ram_we = w_ram_do & WE & ~RST;

  always_ff @(posedge clk) begin
    if (w_ram_we) r_mem[AD[RAM_AW-1:0]] <= DO;
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_wcnt      <= 4'd0;
      r_di        <= 8'h00;
      r_ext_req   <= 1'b0;
      r_ext_we    <= 1'b0;
      r_ext_addr  <= 16'h0000;
      r_ext_wdata <= 8'h00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_ram_hit) begin
            if (!WE) r_di <= r_mem[AD[RAM_AW-1:0]];
          end else if (w_io_hit) begin
            if (IO_ZERO) begin
              if (!WE) r_di <= w_io_rdata;
            end else begin
              r_state <= ST_IOWAIT;
              r_wcnt  <= WAIT_INIT;
            end
          end else begin
            r_state     <= ST_EXT;
            r_ext_req   <= 1'b1;
            r_ext_addr  <= AD;
            r_ext_we    <= WE;
            r_ext_wdata <= DO;
          end
        end
        ST_IOWAIT: begin
          if (r_wcnt == 4'd0) begin
            r_state <= ST_IDLE;
            if (!WE) r_di <= w_io_rdata;
          end else begin
            r_wcnt <= r_wcnt - 4'd1;
          end
        end
        ST_EXT: begin
          if (ext_ack) begin
            r_state   <= ST_IDLE;
            r_ext_req <= 1'b0;
            if (!r_ext_we) r_di <= ext_rdata;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  io_regs u_io_regs (
    .clk       (clk),
    .rst       (RST),
    .i_acc     (w_io_acc),
    .i_we      (WE),
    .i_sel     (AD[1:0]),
    .i_wdata   (DO),
    .i_irq_src (irq_src),
    .o_rdata   (w_io_rdata),
    .o_irq     (IRQ)
  );

  assign DI        = r_di;
  assign ext_req   = r_ext_req & ~RST;
  assign ext_we    = r_ext_we;
  assign ext_addr  = r_ext_addr;
  assign ext_wdata = r_ext_wdata;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_bus_resp.sv
// Directed bench for bus_resp: RAM, wait-stated I/O page, interrupt status,
// external bus handshake, reset abandonment and the cycle counter.
module tb_bus_resp;
  import bus_resp_pkg::*;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] AD = 16'h0FFF;
  logic [7:0]  DO = 8'h00;
  logic        WE = 1'b1;
  logic [7:0]  irq_src = 8'h00;
  logic [7:0]  ext_rdata = 8'h00;
  logic        ext_ack = 1'b0;
  logic [7:0]  DI;
  logic        RDY;
  logic        IRQ;
  logic        ext_req;
  logic        ext_we;
  logic [15:0] ext_addr;
  logic [7:0]  ext_wdata;
  state_t      dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] v_a, v_b, v_c, v_diff;

  bus_resp #(.RAM_AW(12), .IO_PAGE(8'hD0), .IO_WAIT(2)) dut (
    .clk(clk), .RST(RST), .AD(AD), .DO(DO), .WE(WE), .DI(DI), .RDY(RDY),
    .IRQ(IRQ), .irq_src(irq_src), .ext_req(ext_req), .ext_we(ext_we),
    .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_rdata(ext_rdata),
    .ext_ack(ext_ack), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change at the falling edge; checks run 1 time unit later.
  task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic w,
                       input logic [7:0] irq = 8'h00, input logic ack = 1'b0,
                       input logic [7:0] rd = 8'h00);
    @(negedge clk);
    AD = a; DO = d; WE = w; irq_src = irq; ext_ack = ack; ext_rdata = rd;
    #1;
  endtask

  task automatic idle();
    drive(16'h0FFF, 8'h00, 1'b1);
  endtask

  task automatic io_access(input string tag, input logic [15:0] a, input logic [7:0] d,
                           input logic w);
    drive(a, d, w);
    check({tag, "_rdy0"}, 16'(RDY), 16'd0);
    drive(a, d, w);
    check({tag, "_rdy1"}, 16'(RDY), 16'd0);
    check({tag, "_st"}, 16'(dbg_state), 16'(ST_IOWAIT));
    drive(a, d, w);
    check({tag, "_rdy2"}, 16'(RDY), 16'd1);
  endtask

  initial begin
    // Reset
    RST = 1'b1;
    repeat (3) begin
      drive(16'h0FFF, 8'h00, 1'b1);
      check("rst_rdy", 16'(RDY), 16'd1);
      check("rst_ext_req", 16'(ext_req), 16'd0);
    end
    @(negedge clk); RST = 1'b0; #1;
    check("rst_di", 16'(DI), 16'h00);
    check("rst_irq", 16'(IRQ), 16'd0);
    check("rst_state", 16'(dbg_state), 16'(ST_IDLE));

    // RAM write then read, no stall
    drive(16'h0010, 8'h5A, 1'b1);
    check("ram_wr_rdy", 16'(RDY), 16'd1);
    drive(16'h0010, 8'h00, 1'b0);
    check("ram_rd_rdy", 16'(RDY), 16'd1);
    check("ram_rd_di_old", 16'(DI), 16'h00);
    idle();
    check("ram_rd_di", 16'(DI), 16'h5A);

    // I/O enable and scratch with two wait states
    io_access("en_wr", 16'hD002, 8'h81, 1'b1);
    io_access("en_rd", 16'hD002, 8'h00, 1'b0);
    idle();
    check("en_rd_di", 16'(DI), 16'h81);
    io_access("scr_wr", 16'hD000, 8'hA5, 1'b1);
    io_access("scr_rd", 16'hD0FC, 8'h00, 1'b0);
    idle();
    check("scr_alias_di", 16'(DI), 16'hA5);

    // Interrupt set, clear, simultaneous set/clear, masked source
    io_access("en1_wr", 16'hD002, 8'h01, 1'b1);
    drive(16'h0FFF, 8'h00, 1'b1, 8'h01);
    idle();
    idle();
    check("irq_set", 16'(IRQ), 16'd1);
    io_access("st_rd", 16'hD001, 8'h00, 1'b0);
    idle();
    check("st_rd_di", 16'(DI), 16'h01);
    io_access("st_clr", 16'hD001, 8'h01, 1'b1);
    idle();
    idle();
    check("irq_clr", 16'(IRQ), 16'd0);
    drive(16'hD001, 8'h01, 1'b1);
    drive(16'hD001, 8'h01, 1'b1);
    drive(16'hD001, 8'h01, 1'b1, 8'h01);
    check("st_race_rdy", 16'(RDY), 16'd1);
    io_access("st_race_rd", 16'hD001, 8'h00, 1'b0);
    idle();
    check("st_race_di", 16'(DI), 16'h01);
    io_access("st_clr_all", 16'hD001, 8'hFF, 1'b1);
    drive(16'h0FFF, 8'h00, 1'b1, 8'h80);
    idle();
    idle();
    check("irq_masked", 16'(IRQ), 16'd0);
    io_access("st_mask_rd", 16'hD001, 8'h00, 1'b0);
    idle();
    check("st_mask_di", 16'(DI), 16'h80);

    // External read with ack after 3 wait cycles
    drive(16'hFFFC, 8'h00, 1'b0);
    check("ext_idle_rdy", 16'(RDY), 16'd0);
    check("ext_idle_req", 16'(ext_req), 16'd0);
    for (int i = 0; i < 3; i++) begin
      drive(16'hFFFC, 8'h00, 1'b0);
      check("ext_wait_rdy", 16'(RDY), 16'd0);
      check("ext_wait_req", 16'(ext_req), 16'd1);
      check("ext_wait_addr", ext_addr, 16'hFFFC);
      check("ext_wait_we", 16'(ext_we), 16'd0);
    end
    drive(16'hFFFC, 8'h00, 1'b0, 8'h00, 1'b1, 8'h34);
    check("ext_ack_rdy", 16'(RDY), 16'd1);
    check("ext_ack_req", 16'(ext_req), 16'd1);
    idle();
    check("ext_done_req", 16'(ext_req), 16'd0);
    check("ext_done_di", 16'(DI), 16'h34);
    check("ext_done_st", 16'(dbg_state), 16'(ST_IDLE));

    // External write at first non-RAM address; ack in IDLE is ignored
    drive(16'h1000, 8'hC3, 1'b1, 8'h00, 1'b1, 8'h00);
    check("extw_idle_rdy", 16'(RDY), 16'd0);
    check("extw_idle_st", 16'(dbg_state), 16'(ST_IDLE));
    drive(16'h1000, 8'hC3, 1'b1, 8'h00, 1'b1, 8'h00);
    check("extw_rdy", 16'(RDY), 16'd1);
    check("extw_req", 16'(ext_req), 16'd1);
    check("extw_we", 16'(ext_we), 16'd1);
    check("extw_addr", ext_addr, 16'h1000);
    check("extw_wdata", 16'(ext_wdata), 16'h00C3);
    idle();
    check("extw_done_req", 16'(ext_req), 16'd0);
    check("extw_di_hold", 16'(DI), 16'h34);

    // Reset in the middle of an external access
    drive(16'h4000, 8'h00, 1'b0);
    drive(16'h4000, 8'h00, 1'b0);
    check("rste_req_before", 16'(ext_req), 16'd1);
    check("rste_st_before", 16'(dbg_state), 16'(ST_EXT));
    @(negedge clk); RST = 1'b1; #1;
    check("rste_req", 16'(ext_req), 16'd0);
    check("rste_rdy", 16'(RDY), 16'd1);
    @(negedge clk); RST = 1'b0; AD = 16'h0FFF; WE = 1'b1; DO = 8'h00; #1;
    check("rste_st", 16'(dbg_state), 16'(ST_IDLE));
    check("rste_di", 16'(DI), 16'h00);
    check("rste_irq", 16'(IRQ), 16'd0);
    io_access("rste_scr", 16'hD000, 8'h00, 1'b0);
    idle();
    check("rste_scr_di", 16'(DI), 16'h00);

    // Counter: elapsed cycles between reads, write ignored
    io_access("cnt_a", 16'hD003, 8'h00, 1'b0);
    idle();
    v_a = DI;
    io_access("cnt_b", 16'hD003, 8'h00, 1'b0);
    idle();
    v_b = DI;
    v_diff = v_b - v_a;
    check("cnt_diff4", 16'(v_diff), 16'd4);
    io_access("cnt_wr", 16'hD003, 8'h77, 1'b1);
    io_access("cnt_c", 16'hD003, 8'h00, 1'b0);
    idle();
    v_c = DI;
    v_diff = v_c - v_b;
    check("cnt_diff7", 16'(v_diff), 16'd7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
